// File: rtl/spi_rx_frame_sync.sv
// rtl/spi_rx_frame_sync.sv - SPI slave frame tracker and byte FIFO in the clk domain
module spi_rx_frame_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int MIN_LOW_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spi_cs_n,
  input  logic [7:0]               spi_rx_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     overflow,
  output logic                     runt,
  input  logic                     flag_clr,
  output logic [15:0]              frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MIN_LOW_CYC + 1);
  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [LW-1:0] MIN_V   = LW'(MIN_LOW_CYC);

  typedef enum logic [1:0] {IDLE, ACTIVE, CAPTURE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   cs_s;
  logic [LW-1:0]          low_cnt;
  logic [7:0]             mem [DEPTH];
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic                   pop;
  logic                   push_req;
  logic                   push;
  logic                   ovf_set;
  logic                   runt_set;

  // Chain resets to idle-high so release never looks like a CS falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_sync <= '1;
    else        cs_sync <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
  end

  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign busy       = ~cs_s;
  assign fifo_count = wr_ptr - rd_ptr;
  assign out_valid  = (fifo_count != '0);
  assign out_data   = mem[rd_ptr[AW-1:0]];
  assign pop        = out_valid && out_ready;
  assign push_req   = (state == CAPTURE);
  assign push       = push_req && ((fifo_count != DEPTH_V) || pop);
  assign ovf_set    = push_req && !push;
  assign runt_set   = (state == ACTIVE) && cs_s && (low_cnt < MIN_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      low_cnt   <= '0;
      frame_cnt <= '0;
      runt      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state   <= ACTIVE;
            low_cnt <= LW'(1);
          end
        end
        ACTIVE: begin
          if (!cs_s) begin
            if (low_cnt < MIN_V) low_cnt <= low_cnt + LW'(1);
          end else if (low_cnt >= MIN_V) begin
            state <= CAPTURE;
          end else begin
            state <= IDLE;
          end
        end
        CAPTURE: begin
          frame_cnt <= frame_cnt + 16'd1;
          if (!cs_s) begin
            state   <= ACTIVE;
            low_cnt <= LW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (runt_set)      runt <= 1'b1;
      else if (flag_clr) runt <= 1'b0;

      if (ovf_set)       overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;
    end
  end

  // Memory is reset so out_data reads 0 while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= spi_rx_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_spi_rx_frame_sync.sv
// tb/tb_spi_rx_frame_sync.sv - directed self-checking bench for spi_rx_frame_sync
module tb_spi_rx_frame_sync;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int MINL  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_n;
  logic [7:0]  spi_rx_data;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  fifo_count;
  logic        busy;
  logic        overflow;
  logic        runt;
  logic        flag_clr;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_frames = 0;

  spi_rx_frame_sync #(.SYNC_STAGES(SYNC), .DEPTH(DEPTH), .MIN_LOW_CYC(MINL)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_rx_data(spi_rx_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .fifo_count(fifo_count), .busy(busy), .overflow(overflow), .runt(runt),
    .flag_clr(flag_clr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int low);
    spi_rx_data = d;
    spi_cs_n    = 1'b0;
    tick(low);
    spi_cs_n    = 1'b1;
    tick(SYNC + 4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_rx_data = 8'h00; out_ready = 1'b0; flag_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(50);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frames got=%0d exp=0", frame_cnt); end
    checks++; if (runt !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags runt=%b ovf=%b busy=%b exp=000", runt, overflow, busy); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
  endtask

  task automatic test_single;
    int n;
    spi_rx_data = 8'hA5;
    spi_cs_n    = 1'b0;
    tick(40);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    spi_cs_n = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < SYNC + 3) begin tick(1); n++; end
    exp_frames++;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1 within %0d clk", out_valid, SYNC + 3); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL single_frames got=%0d exp=%0d", frame_cnt, exp_frames); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_pop count=%0d valid=%b exp=0/0", fifo_count, out_valid); end
    tick(2);
  endtask

  task automatic test_overflow;
    logic [7:0] exp_q [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8);
      exp_frames++;
    end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL ovf_frames got=%0d exp=%0d", frame_cnt, exp_frames); end
    tick(3);
    checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ovf_hold data=%h valid=%b exp=01/1", out_data, out_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_q[i]) begin failures++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, out_data, exp_q[i]); end
      out_ready = 1'b1; tick(1); out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_runt;
    send_frame(8'hEE, 2);
    checks++; if (runt !== 1'b1) begin failures++; $display("FAIL runt_flag got=%b exp=1", runt); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL runt_nopush got=%0d exp=0", fifo_count); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL runt_frames got=%0d exp=%0d", frame_cnt, exp_frames); end
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    checks++; if (runt !== 1'b0) begin failures++; $display("FAIL runt_clear got=%b exp=0", runt); end
    send_frame(8'hD3, MINL - 1);
    checks++; if (runt !== 1'b1 || fifo_count !== 3'd0) begin
      failures++; $display("FAIL runt_min1 runt=%b count=%0d exp=1/0", runt, fifo_count); end
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    send_frame(8'h4D, MINL);
    exp_frames++;
    checks++; if (runt !== 1'b0 || out_data !== 8'h4D || fifo_count !== 3'd1) begin
      failures++; $display("FAIL runt_min runt=%b data=%h count=%0d exp=0/4d/1", runt, out_data, fifo_count); end
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
  endtask

  task automatic test_full_pop;
    logic [7:0] exp_q [4] = '{8'h11, 8'h12, 8'h13, 8'h77};
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h10 + 8'(i), 8);
      exp_frames++;
    end
    spi_rx_data = 8'h77;
    spi_cs_n    = 1'b0;
    tick(8);
    spi_cs_n = 1'b1;
    tick(3);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    tick(3);
    exp_frames++;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", fifo_count); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL fullpop_frames got=%0d exp=%0d", frame_cnt, exp_frames); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_q[i]) begin failures++; $display("FAIL fullpop_drain%0d got=%h exp=%h", i, out_data, exp_q[i]); end
      out_ready = 1'b1; tick(1); out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    spi_rx_data = 8'hB1;
    spi_cs_n    = 1'b0;
    tick(8);
    spi_cs_n = 1'b1;
    tick(1);
    spi_cs_n = 1'b0;
    tick(4);
    spi_rx_data = 8'hB2;
    tick(8);
    spi_cs_n = 1'b1;
    tick(SYNC + 4);
    exp_frames += 2;
    checks++; if (fifo_count !== 3'd2 || runt !== 1'b0) begin
      failures++; $display("FAIL b2b_count count=%0d runt=%b exp=2/0", fifo_count, runt); end
    checks++; if (frame_cnt !== 16'(exp_frames)) begin failures++; $display("FAIL b2b_frames got=%0d exp=%0d", frame_cnt, exp_frames); end
    checks++; if (out_data !== 8'hB1) begin failures++; $display("FAIL b2b_first got=%h exp=b1", out_data); end
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    checks++; if (out_data !== 8'hB2) begin failures++; $display("FAIL b2b_second got=%h exp=b2", out_data); end
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    send_frame(8'h55, 8);
    spi_rx_data = 8'h99;
    spi_cs_n    = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || out_data !== 8'h00) begin
      failures++; $display("FAIL rstmid_outs valid=%b count=%0d busy=%b data=%h exp=0", out_valid, fifo_count, busy, out_data); end
    checks++; if (frame_cnt !== 16'd0 || runt !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL rstmid_state frames=%0d runt=%b ovf=%b exp=0", frame_cnt, runt, overflow); end
    tick(2);
    rst_n = 1'b1;
    spi_rx_data = 8'h3C;
    tick(10);
    spi_cs_n = 1'b1;
    tick(SYNC + 4);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || fifo_count !== 3'd1) begin
      failures++; $display("FAIL rstmid_frame valid=%b data=%h count=%0d exp=1/3c/1", out_valid, out_data, fifo_count); end
    checks++; if (frame_cnt !== 16'd1 || runt !== 1'b0) begin
      failures++; $display("FAIL rstmid_frames frames=%0d runt=%b exp=1/0", frame_cnt, runt); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_runt;
    test_full_pop;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
